// File: rtl/q_8_25_pkg.sv
// q_8_25_pkg: shared widths and controller state encoding for the shift-add multiplier
package q_8_25_pkg;
    localparam int dp_width = 5;
    localparam int bc_size  = 3;
    localparam int st_width = 2;
    typedef enum logic [st_width-1:0] {S_idle, S_add, S_shift} state_t;
endpackage

// File: rtl/q_8_25_datapath.sv
// q_8_25_datapath: operand/accumulator registers, adder and shifters of the multiplier (SMART_SKIP_EN enables early finish)
module q_8_25_datapath
    import q_8_25_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    load_i,
    input  logic                    decr_i,
    input  logic                    add_i,
    input  logic                    shift_i,
    input  logic                    skip_i,
    input  logic [dp_width-1:0]     multiplicand_i,
    input  logic [dp_width-1:0]     multiplier_i,
    output logic                    q0_o,
    output logic                    p_zero_o,
    output logic                    m_zero_o,
    output logic [2*dp_width-1:0]   product_o
);
    localparam int pw = 2*dp_width;
    logic [dp_width-1:0] a_q, a_d, b_q, b_d, q_q, q_d, m_q, m_d;
    logic                c_q, c_d;
    logic [bc_size-1:0]  p_q, p_d;
    logic [pw:0]         caq, caq_shp;
    assign caq       = {c_q, a_q, q_q};
    assign caq_shp   = caq >> p_q;
    assign q0_o      = q_q[0];
    assign p_zero_o  = (p_q == '0);
    assign product_o = {a_q, q_q};
`ifdef SMART_SKIP_EN
    assign m_zero_o  = (m_q == '0);
`else
    assign m_zero_o  = 1'b0;
`endif
    // next register values: load operands, jump over the zero tail, or one add/shift step
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        q_d = q_q;
        m_d = m_q;
        c_d = c_q;
        p_d = p_q;
        if (load_i) begin
            a_d = '0;
            c_d = 1'b0;
            b_d = multiplicand_i;
            q_d = multiplier_i;
            m_d = multiplier_i;
            p_d = bc_size'(dp_width);
        end else if (skip_i) begin
            {a_d, q_d} = caq_shp[pw-1:0];
            c_d = 1'b0;
        end else begin
            if (decr_i)
                p_d = p_q - bc_size'(1);
            if (add_i)
                {c_d, a_d} = {1'b0, a_q} + {1'b0, b_q};
            if (shift_i) begin
                {c_d, a_d, q_d} = {1'b0, caq[pw:1]};
                m_d = m_q >> 1;
            end
        end
    end
    // register bank, cleared by reset so the product reads zero
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q <= '0;
            b_q <= '0;
            q_q <= '0;
            m_q <= '0;
            c_q <= 1'b0;
            p_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            q_q <= q_d;
            m_q <= m_d;
            c_q <= c_d;
            p_q <= p_d;
        end
    end
endmodule

// File: rtl/q_8_25.sv
// q_8_25: sequential shift-add unsigned multiplier controller (SMART_SKIP_EN enables early finish)
module q_8_25
    import q_8_25_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  start,
    input  logic [dp_width-1:0]   multiplicand,
    input  logic [dp_width-1:0]   multiplier,
    output logic                  rdy,
    output logic [2*dp_width-1:0] product
);
    state_t state_q, state_d;
    logic load_regs, decr_p, add_regs, shift_regs, skip_regs;
    logic cntr_eq_zero, s_multiplier_eq_zero, q0;
    assign rdy        = (state_q == S_idle);
    assign load_regs  = rdy && start;
    assign decr_p     = (state_q == S_add) && !s_multiplier_eq_zero;
    assign add_regs   = decr_p && q0;
    assign skip_regs  = (state_q == S_add) && s_multiplier_eq_zero;
    assign shift_regs = (state_q == S_shift);
    // next state: idle waits for start, add either steps or finishes early, shift loops until count is spent
    always_comb begin
        state_d = (state_q == S_idle)  ? (start ? S_add : S_idle) :
                  (state_q == S_add)   ? (s_multiplier_eq_zero ? S_idle : S_shift) :
                  (state_q == S_shift) ? (cntr_eq_zero ? S_idle : S_add) : S_idle;
    end
    // state register, reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b)
            state_q <= S_idle;
        else
            state_q <= state_d;
    end
    q_8_25_datapath u_dp (
        .clk_i          (clk),
        .rst_i          (rst_b),
        .load_i         (load_regs),
        .decr_i         (decr_p),
        .add_i          (add_regs),
        .shift_i        (shift_regs),
        .skip_i         (skip_regs),
        .multiplicand_i (multiplicand),
        .multiplier_i   (multiplier),
        .q0_o           (q0),
        .p_zero_o       (cntr_eq_zero),
        .m_zero_o       (s_multiplier_eq_zero),
        .product_o      (product)
    );
endmodule

// File: tb/tb_q_8_25.sv
// tb_q_8_25: randomized self-checking bench for the q_8_25 multiplier against an arithmetic reference
module tb_q_8_25;
    logic       clk = 1'b0;
    logic       rst_b = 1'b1;
    logic       start = 1'b0;
    logic [4:0] multiplicand = '0;
    logic [4:0] multiplier = '0;
    logic       rdy;
    logic [9:0] product;
    int n_cmp = 0;
    int n_err = 0;
    q_8_25 dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .rdy          (rdy),
        .product      (product)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask
    // busy cycles: one add+shift pair per significant multiplier bit, plus one skip cycle unless all bits used
    function automatic int exp_lat(input int y);
`ifdef SMART_SKIP_EN
        int n = 0;
        while ((y >> n) != 0) n++;
        return (n == 5) ? 10 : 2*n + 1;
`else
        return (y >= 0) ? 10 : 10;
`endif
    endfunction
    task automatic run_op(input int x, input int y, input string tag);
        int lat = 0;
        @(negedge clk);
        multiplicand = 5'(x);
        multiplier = 5'(y);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        multiplicand = 5'($urandom);
        multiplier = 5'($urandom);
        @(negedge clk);
        while (!rdy && lat < 40) begin
            lat++;
            start = (lat == 1);
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_lat"}, lat, exp_lat(y));
        check({tag, "_prod"}, 32'(product), x * y);
    endtask
    initial begin
        int k, off, idx, x, y, lat;
        #3;
        check("rst_rdy", 32'(rdy), 1);
        check("rst_prod", 32'(product), 0);
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b0;
        check("idle_rdy", 32'(rdy), 1);
        run_op(31, 31, "m31x31");
        run_op(7, 0, "m7x0");
        run_op(3, 1, "m3x1");
        run_op(0, 31, "m0x31");
        for (int i = 0; i < 20; i++)
            run_op(int'($urandom_range(31)), int'($urandom_range(31)), "rand");
        @(negedge clk);
        multiplicand = 5'd21;
        multiplier = 5'd13;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_b = 1'b1;
        #1;
        check("abort_rdy", 32'(rdy), 1);
        check("abort_prod", 32'(product), 0);
        @(negedge clk);
        rst_b = 1'b0;
        run_op(21, 13, "restart");
        k = 2 * int'($urandom_range(511)) + 1;
        off = int'($urandom_range(1023));
        @(negedge clk);
        idx = off;
        x = idx / 32;
        y = idx % 32;
        multiplicand = 5'(x);
        multiplier = 5'(y);
        start = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            lat = 0;
            @(posedge clk);
            @(negedge clk);
            while (!rdy && lat < 40) begin
                lat++;
                @(negedge clk);
            end
            check("sweep_lat", lat, exp_lat(y));
            check("sweep_prod", 32'(product), x * y);
            idx = (idx + k) % 1024;
            x = idx / 32;
            y = idx % 32;
            multiplicand = 5'(x);
            multiplier = 5'(y);
            if (i == 1023) start = 1'b0;
        end
        @(negedge clk);
        check("end_rdy", 32'(rdy), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
